// File: rtl/mac_accumulator.sv
// Sequential signed multiply-accumulate for one neuron: bias preload, streamed
// (input, weight) pairs with saturating accumulation, held handshaked result.
module mac_accumulator #(
    parameter int DATA_WIDTH = 8,
    parameter int ACC_WIDTH  = 32,
    parameter int MAX_LEN    = 256,
    parameter int CNT_WIDTH  = 9
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  len,
    input  logic [ACC_WIDTH-1:0]  bias,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] weight_in,
    output logic [ACC_WIDTH-1:0]  acc_out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  sat_flag
);

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    state_t state, state_nxt;

    logic signed [ACC_WIDTH-1:0]    acc;
    logic [CNT_WIDTH-1:0]           cnt;
    logic [CNT_WIDTH-1:0]           len_clamped;
    logic                           beat;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_WIDTH:0]      sum;
    logic signed [ACC_WIDTH-1:0]    sat_sum;
    logic                           sat_hit;

    assign len_clamped = (len > CNT_WIDTH'(MAX_LEN)) ? CNT_WIDTH'(MAX_LEN) : len;
    assign in_ready    = (state == ACCUM);
    assign busy        = (state != IDLE);
    assign beat        = in_valid & in_ready;

    assign prod = $signed(data_in) * $signed(weight_in);
    assign sum  = (ACC_WIDTH+1)'(acc) + (ACC_WIDTH+1)'(prod);

    // One guard bit: the top two sum bits disagree exactly when the result
    // leaves the ACC_WIDTH signed range; the guard bit gives the direction.
    always_comb begin
        sat_hit = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
        sat_sum = sum[ACC_WIDTH-1:0];
        if (sat_hit) begin
            sat_sum = sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                     : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (len_clamped == '0) ? DONE : ACCUM;
            ACCUM:   if (beat && cnt == CNT_WIDTH'(1)) state_nxt = DONE;
            DONE:    if (out_valid && out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            acc_out   <= '0;
            out_valid <= 1'b0;
            sat_flag  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= $signed(bias);
                        cnt      <= len_clamped;
                        sat_flag <= 1'b0;
                        if (len_clamped == '0) begin
                            acc_out   <= bias;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        acc <= sat_sum;
                        cnt <= cnt - CNT_WIDTH'(1);
                        if (sat_hit) sat_flag <= 1'b1;
                        if (cnt == CNT_WIDTH'(1)) begin
                            acc_out   <= sat_sum;
                            out_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) out_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench for mac_accumulator: 32-bit instance for the main behaviour,
// 16-bit instance sharing the same stimulus for saturation.
module tb_mac_accumulator;

    logic        clk;
    logic        rst;
    logic        start;
    logic [8:0]  len;
    logic [31:0] bias32;
    logic [15:0] bias16;
    logic        in_valid;
    logic [7:0]  data_in;
    logic [7:0]  weight_in;
    logic        out_ready;

    logic        in_ready32, out_valid32, busy32, sat32;
    logic [31:0] acc32;
    logic        in_ready16, out_valid16, busy16, sat16;
    logic [15:0] acc16;

    int errors = 0;
    int checks = 0;

    int da[3] = '{2, -4, 127};
    int wa[3] = '{3, 5, -128};

    mac_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(32), .MAX_LEN(256), .CNT_WIDTH(9)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias32),
        .in_valid(in_valid), .in_ready(in_ready32), .data_in(data_in), .weight_in(weight_in),
        .acc_out(acc32), .out_valid(out_valid32), .out_ready(out_ready),
        .busy(busy32), .sat_flag(sat32)
    );

    mac_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(16), .MAX_LEN(256), .CNT_WIDTH(9)) dut16 (
        .clk(clk), .rst(rst), .start(start), .len(len), .bias(bias16),
        .in_valid(in_valid), .in_ready(in_ready16), .data_in(data_in), .weight_in(weight_in),
        .acc_out(acc16), .out_valid(out_valid16), .out_ready(out_ready),
        .busy(busy16), .sat_flag(sat16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; len = '0; bias32 = '0; bias16 = '0;
        in_valid = 1'b0; data_in = '0; weight_in = '0; out_ready = 1'b0;
        tick(); tick();

        check("rst_acc_out",   acc32,       32'd0);
        check("rst_out_valid", out_valid32, 32'd0);
        check("rst_busy",      busy32,      32'd0);
        check("rst_in_ready",  in_ready32,  32'd0);
        check("rst_sat",       sat32,       32'd0);
        rst = 1'b0;
        tick();

        // basic dot product, back-to-back beats
        out_ready = 1'b1;
        start = 1'b1; len = 9'd3; bias32 = 32'd10;
        tick();
        start = 1'b0;
        check("t1_busy",     busy32,     32'd1);
        check("t1_in_ready", in_ready32, 32'd1);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; data_in = 8'(da[i]); weight_in = 8'(wa[i]);
            tick();
            if (i == 1) check("t1_valid_early", out_valid32, 32'd0);
        end
        in_valid = 1'b0;
        check("t1_out_valid", out_valid32, 32'd1);
        check("t1_acc_out",   acc32,       32'(-16260));
        check("t1_sat",       sat32,       32'd0);
        check("t1_in_ready_done", in_ready32, 32'd0);
        tick();
        check("t1_valid_clr", out_valid32, 32'd0);
        check("t1_idle",      busy32,      32'd0);

        // stalls on input, backpressure on output
        out_ready = 1'b0;
        start = 1'b1; len = 9'd3; bias32 = 32'd10;
        tick();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; data_in = 8'(da[i]); weight_in = 8'(wa[i]);
            tick();
            in_valid = 1'b0;
            if (i < 2) begin
                tick(); tick();
                check("t2_stall_ready", in_ready32,  32'd1);
                check("t2_stall_valid", out_valid32, 32'd0);
            end
        end
        for (int i = 0; i < 5; i++) begin
            check("t2_hold_valid", out_valid32, 32'd1);
            check("t2_hold_acc",   acc32,       32'(-16260));
            check("t2_hold_busy",  busy32,      32'd1);
            tick();
        end
        out_ready = 1'b1;
        tick();
        check("t2_valid_clr", out_valid32, 32'd0);
        check("t2_idle",      busy32,      32'd0);

        // saturation on the 16-bit instance; 32-bit instance stays in range
        out_ready = 1'b0;
        start = 1'b1; len = 9'd2; bias16 = 16'd32000; bias32 = 32'd10;
        tick();
        start = 1'b0;
        in_valid = 1'b1; data_in = 8'd127; weight_in = 8'd127;
        tick();
        check("t3_sat_first", sat16,       32'd1);
        check("t3_valid_mid", out_valid16, 32'd0);
        data_in = 8'h80; weight_in = 8'd127;
        tick();
        in_valid = 1'b0;
        check("t3_acc16",   {16'd0, acc16}, 32'd16511);
        check("t3_valid16", out_valid16,    32'd1);
        check("t3_sat16",   sat16,          32'd1);
        check("t3_acc32",   acc32,          32'(-117));
        check("t3_sat32",   sat32,          32'd0);
        out_ready = 1'b1;
        tick();

        // len = 0: bias passes straight through
        out_ready = 1'b0;
        start = 1'b1; len = 9'd0; bias32 = 32'(-5);
        check("t4_ready_idle", in_ready32, 32'd0);
        tick();
        start = 1'b0;
        check("t4_out_valid", out_valid32, 32'd1);
        check("t4_acc_out",   acc32,       32'(-5));
        check("t4_in_ready",  in_ready32,  32'd0);
        check("t4_sat16_clr", sat16,       32'd0);
        out_ready = 1'b1;
        tick();
        check("t4_valid_clr", out_valid32, 32'd0);

        // clamp len=511 to 256 beats, start during ACCUM ignored
        out_ready = 1'b0;
        start = 1'b1; len = 9'd511; bias32 = 32'd0;
        tick();
        start = 1'b0;
        data_in = 8'd1; weight_in = 8'd1; in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            start  = (i == 10);
            len    = (i == 10) ? 9'd3 : 9'd511;
            bias32 = (i == 10) ? 32'd999 : 32'd0;
            tick();
            if (i == 254) begin
                check("t5_valid_early", out_valid32, 32'd0);
                check("t5_ready_mid",   in_ready32,  32'd1);
            end
        end
        start = 1'b0;
        check("t5_out_valid", out_valid32, 32'd1);
        check("t5_acc_out",   acc32,       32'd256);
        tick();
        check("t5_no_ready", in_ready32, 32'd0);
        check("t5_acc_hold", acc32,      32'd256);
        in_valid = 1'b0; out_ready = 1'b1;
        tick();

        // asynchronous reset mid-neuron
        out_ready = 1'b0;
        start = 1'b1; len = 9'd4; bias32 = 32'd100;
        tick();
        start = 1'b0;
        in_valid = 1'b1; data_in = 8'd3; weight_in = 8'd3;
        tick(); tick();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t6_acc_out",   acc32,       32'd0);
        check("t6_out_valid", out_valid32, 32'd0);
        check("t6_busy",      busy32,      32'd0);
        check("t6_in_ready",  in_ready32,  32'd0);
        check("t6_sat",       sat32,       32'd0);
        tick();
        rst = 1'b0;
        tick();
        start = 1'b1; len = 9'd1; bias32 = 32'd1;
        tick();
        start = 1'b0;
        in_valid = 1'b1; data_in = 8'd1; weight_in = 8'd1;
        tick();
        in_valid = 1'b0;
        check("t6_new_valid", out_valid32, 32'd1);
        check("t6_new_acc",   acc32,       32'd2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
